// File: rtl/sccb_master.sv
// SCCB master for OV-series camera sensors.
// It runs 3-phase writes (ID, address byte(s), data) and reads (an ID and address
// write, a STOP and a gap, then an ID|1 phase and a receive phase). SIO_D is tri-state.
// It uses a start/busy/done handshake. All bus transitions occur on SIO_C half-period boundaries.
module sccb_master #(
    parameter int unsigned HALF_PERIOD = 4,
    parameter logic [7:0]  SLAVE_ID    = 8'h42,
    parameter int unsigned ADDR_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              rw,
    input  logic [ADDR_W-1:0] reg_address,
    input  logic [7:0]        reg_data,
    output logic              busy,
    output logic              done,
    output logic [7:0]        rd_data,
    output logic              sio_c,
    output logic              sio_d_out,
    output logic              sio_d_oe,
    input  logic              sio_d_in
);

    localparam int unsigned     NA       = ADDR_W / 8;
    localparam int unsigned     CW       = $clog2(2 * HALF_PERIOD);
    localparam logic [CW-1:0]   HALF_END = CW'(HALF_PERIOD - 1);
    localparam logic [CW-1:0]   GAP_END  = CW'(2 * HALF_PERIOD - 1);
    localparam logic [1:0]      LAST_W   = 2'(NA + 1);
    localparam logic [1:0]      LAST_R   = 2'(NA);

    typedef enum logic [3:0] {
        IDLE, START, BIT_LO, BIT_HI, STOP_A, STOP_B, STOP_C, GAP, DONE
    } state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [1:0]        phase;
    logic [3:0]        bit_idx;
    logic              rd_sec;
    logic              rw_l;
    logic [ADDR_W-1:0] addr_l;
    logic [7:0]        data_l;
    logic [7:0]        rx_sh;

    logic              half_end;
    logic              last_phase;
    logic              rx_now;
    logic [1:0]        tgt_phase;
    logic [3:0]        tgt_bit;
    logic [7:0]        tx_byte;
    logic              rx_phase;
    logic              nxt_out;
    logic              nxt_oe;

    // Work out the phase and bit about to be entered on the next BIT_LO, and its SIO_D drive
    always_comb begin
        half_end   = (cnt == HALF_END);
        last_phase = rd_sec ? (phase == 2'd1) : (phase == (rw_l ? LAST_R : LAST_W));
        rx_now     = rd_sec && (phase == 2'd1) && (bit_idx != 4'd8);

        tgt_phase = phase;
        tgt_bit   = 4'd0;
        if (state == BIT_HI) begin
            if (bit_idx == 4'd8)
                tgt_phase = phase + 2'd1;
            else
                tgt_bit = bit_idx + 4'd1;
        end

        tx_byte  = '0;
        rx_phase = 1'b0;
        if (rd_sec) begin
            if (tgt_phase == 2'd0)
                tx_byte = SLAVE_ID | 8'h01;
            else
                rx_phase = 1'b1;
        end else if (tgt_phase == 2'd0) begin
            tx_byte = SLAVE_ID;
        end else if (tgt_phase <= 2'(NA)) begin
            // With a 16-bit address, phase 1 carries the MSB byte and the last address phase carries the LSB byte
            if (NA == 2 && tgt_phase == 2'd1)
                tx_byte = addr_l[ADDR_W-1 -: 8];
            else
                tx_byte = addr_l[7:0];
        end else begin
            tx_byte = data_l;
        end

        nxt_out = 1'b1;
        nxt_oe  = 1'b1;
        if (tgt_bit == 4'd8)
            nxt_oe = rx_phase;
        else if (rx_phase)
            nxt_oe = 1'b0;
        else
            nxt_out = tx_byte[3'd7 - tgt_bit[2:0]];
    end

    // Transaction sequencer: half-period divider, bit and phase counters, and registered bus outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            phase     <= '0;
            bit_idx   <= '0;
            rd_sec    <= 1'b0;
            rw_l      <= 1'b0;
            addr_l    <= '0;
            data_l    <= '0;
            rx_sh     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rd_data   <= '0;
            sio_c     <= 1'b1;
            sio_d_out <= 1'b1;
            sio_d_oe  <= 1'b1;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    sio_c     <= 1'b1;
                    sio_d_out <= 1'b1;
                    sio_d_oe  <= 1'b1;
                    if (start) begin
                        rw_l      <= rw;
                        addr_l    <= reg_address;
                        data_l    <= reg_data;
                        busy      <= 1'b1;
                        sio_d_out <= 1'b0;
                        cnt       <= '0;
                        phase     <= '0;
                        bit_idx   <= '0;
                        rd_sec    <= 1'b0;
                        state     <= START;
                    end
                end
                START: begin
                    if (half_end) begin
                        cnt       <= '0;
                        sio_c     <= 1'b0;
                        sio_d_out <= nxt_out;
                        sio_d_oe  <= nxt_oe;
                        phase     <= tgt_phase;
                        bit_idx   <= tgt_bit;
                        state     <= BIT_LO;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                BIT_LO: begin
                    if (half_end) begin
                        cnt   <= '0;
                        sio_c <= 1'b1;
                        state <= BIT_HI;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                BIT_HI: begin
                    if (half_end) begin
                        cnt   <= '0;
                        sio_c <= 1'b0;
                        if (rx_now)
                            rx_sh <= {rx_sh[6:0], sio_d_in};
                        if (bit_idx == 4'd8 && last_phase) begin
                            sio_d_out <= 1'b0;
                            sio_d_oe  <= 1'b1;
                            state     <= STOP_A;
                        end else begin
                            sio_d_out <= nxt_out;
                            sio_d_oe  <= nxt_oe;
                            phase     <= tgt_phase;
                            bit_idx   <= tgt_bit;
                            state     <= BIT_LO;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP_A: begin
                    if (half_end) begin
                        cnt   <= '0;
                        sio_c <= 1'b1;
                        state <= STOP_B;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP_B: begin
                    if (half_end) begin
                        cnt       <= '0;
                        sio_d_out <= 1'b1;
                        state     <= STOP_C;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP_C: begin
                    if (half_end) begin
                        cnt <= '0;
                        if (rw_l && !rd_sec) begin
                            state <= GAP;
                        end else begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            if (rw_l)
                                rd_data <= rx_sh;
                            state <= DONE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                GAP: begin
                    if (cnt == GAP_END) begin
                        cnt       <= '0;
                        rd_sec    <= 1'b1;
                        phase     <= '0;
                        bit_idx   <= '0;
                        sio_d_out <= 1'b0;
                        state     <= START;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sccb_master.sv
// Directed bench for sccb_master. It uses one 8-bit-address instance and one 16-bit-address instance.
// A bus monitor records SIO_D at every SIO_C rise and counts START/STOP, busy and done.
// A slave model returns the read byte and ACKs with 0.
module tb_sccb_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start8 = 1'b0;
    logic        start16 = 1'b0;
    logic        rw = 1'b0;
    logic [15:0] addr = '0;
    logic [7:0]  data = '0;

    logic        busy8, done8, c8, dout8, oe8;
    logic        busy16, done16, c16, dout16, oe16;
    logic [7:0]  rd8, rd16;
    logic        pad8, pad16, slave_drv;

    int n_vec = 0;
    int n_err = 0;

    logic       sel16 = 1'b0;
    logic       rd_mode = 1'b0;
    logic [7:0] rxv = 8'hA5;
    logic       mon_clr = 1'b1;

    always #5 clk = ~clk;

    assign pad8  = oe8  ? dout8  : slave_drv;
    assign pad16 = oe16 ? dout16 : slave_drv;

    sccb_master #(.HALF_PERIOD(4), .SLAVE_ID(8'h42), .ADDR_W(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .rw(rw), .reg_address(addr[7:0]),
        .reg_data(data), .busy(busy8), .done(done8), .rd_data(rd8), .sio_c(c8),
        .sio_d_out(dout8), .sio_d_oe(oe8), .sio_d_in(pad8)
    );

    sccb_master #(.HALF_PERIOD(4), .SLAVE_ID(8'h42), .ADDR_W(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .rw(rw), .reg_address(addr),
        .reg_data(data), .busy(busy16), .done(done16), .rd_data(rd16), .sio_c(c16),
        .sio_d_out(dout16), .sio_d_oe(oe16), .sio_d_in(pad16)
    );

    logic m_c, m_d, m_oe, m_busy, m_done;
    assign m_c    = sel16 ? c16    : c8;
    assign m_d    = sel16 ? pad16  : pad8;
    assign m_oe   = sel16 ? oe16   : oe8;
    assign m_busy = sel16 ? busy16 : busy8;
    assign m_done = sel16 ? done16 : done8;

    logic       rec_d  [64];
    logic       rec_oe [64];
    int         rises, n_start, n_stop, busy_cnt, done_cnt;
    logic [4:0] fcnt;
    logic       pc, pd;

    // Bus monitor, sampled on the falling clock edge
    always @(negedge clk) begin
        if (mon_clr) begin
            rises <= 0; n_start <= 0; n_stop <= 0; busy_cnt <= 0; done_cnt <= 0;
            fcnt <= '0; pc <= 1'b1; pd <= 1'b1;
        end else begin
            if (m_busy) busy_cnt <= busy_cnt + 1;
            if (m_done) done_cnt <= done_cnt + 1;
            if (!pc && m_c) begin
                if (rises < 64) begin
                    rec_d[rises]  <= m_d;
                    rec_oe[rises] <= m_oe;
                end
                rises <= rises + 1;
            end
            if (pc && !m_c) fcnt <= fcnt + 5'd1;
            if (pc && m_c && pd && !m_d) begin
                n_start <= n_start + 1;
                fcnt <= '0;
            end
            if (pc && m_c && !pd && m_d) n_stop <= n_stop + 1;
            pc <= m_c;
            pd <= m_d;
        end
    end

    // Slave: drive the read byte MSB first during bits 9..16 of the second section, otherwise ACK with 0
    always_comb begin
        slave_drv = 1'b0;
        if (rd_mode && n_start == 2 && fcnt >= 5'd10 && fcnt <= 5'd17)
            slave_drv = rxv[3'(5'd17 - fcnt)];
    end

    function automatic logic [7:0] get_byte(input int base);
        logic [7:0] b;
        for (int i = 0; i < 8; i++) b[7-i] = rec_d[base+i];
        return b;
    endfunction

    function automatic logic [7:0] get_oe(input int base);
        logic [7:0] b;
        for (int i = 0; i < 8; i++) b[7-i] = rec_oe[base+i];
        return b;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_tx(input string tag, input int base, input logic [7:0] exp);
        check(tag, {24'd0, get_byte(base)}, {24'd0, exp});
        check({tag, "_oe"}, {24'd0, get_oe(base)}, 32'hFF);
        check({tag, "_bit9_oe"}, {31'd0, rec_oe[base+8]}, 32'd0);
    endtask

    task automatic clr_mon();
        mon_clr = 1'b1;
        @(negedge clk);
        @(negedge clk);
        mon_clr = 1'b0;
    endtask

    task automatic do_start(input logic use16, input logic r, input logic [15:0] a, input logic [7:0] d);
        sel16   = use16;
        rd_mode = r;
        clr_mon();
        rw = r; addr = a; data = d;
        if (use16) start16 = 1'b1; else start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0; start16 = 1'b0;
        check("accept_busy", {31'd0, m_busy}, 32'd1);
        check("start_shape", {30'd0, m_c, m_d}, {30'd0, 2'b10});
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        while (!m_done && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_done_seen"}, {31'd0, m_done}, 32'd1);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("rst_sio_c", {31'd0, c8}, 32'd1);
        check("rst_sio_d", {31'd0, dout8}, 32'd1);
        check("rst_oe", {31'd0, oe8}, 32'd1);
        check("rst_busy", {31'd0, busy8}, 32'd0);
        check("rst_done", {31'd0, done8}, 32'd0);
        check("rst_rd_data", {24'd0, rd8}, 32'd0);

        // Write with an 8-bit address: 0x53 <= 0x0A
        do_start(1'b0, 1'b0, 16'h0053, 8'h0A);
        wait_done("w8");
        chk_tx("w8_id", 0, 8'h42);
        chk_tx("w8_addr", 9, 8'h53);
        chk_tx("w8_data", 18, 8'h0A);
        check("w8_rises", rises, 28);
        check("w8_starts", n_start, 1);
        check("w8_stops", n_stop, 1);
        check("w8_busy_len", busy_cnt, 232);
        check("w8_done_cnt", done_cnt, 1);
        check("w8_rd_data_kept", {24'd0, rd8}, 32'd0);
        check("w8_idle", {29'd0, c8, dout8, oe8}, 32'd7);

        // Read with an 8-bit address: 0x1C, slave returns 0xA5
        do_start(1'b0, 1'b1, 16'h001C, 8'h00);
        wait_done("r8");
        chk_tx("r8_id", 0, 8'h42);
        chk_tx("r8_addr", 9, 8'h1C);
        check("r8_stop1_rise_d", {31'd0, rec_d[18]}, 32'd0);
        chk_tx("r8_id_rd", 19, 8'h43);
        check("r8_rx_oe", {24'd0, get_oe(28)}, 32'h00);
        check("r8_rx_bus", {24'd0, get_byte(28)}, 32'hA5);
        check("r8_na_oe", {31'd0, rec_oe[36]}, 32'd1);
        check("r8_na_d", {31'd0, rec_d[36]}, 32'd1);
        check("r8_rises", rises, 38);
        check("r8_starts", n_start, 2);
        check("r8_stops", n_stop, 2);
        check("r8_busy_len", busy_cnt, 328);
        check("r8_done_cnt", done_cnt, 1);
        check("r8_rd_data", {24'd0, rd8}, 32'hA5);

        // Write with a 16-bit address: 0x300A <= 0x82
        do_start(1'b1, 1'b0, 16'h300A, 8'h82);
        wait_done("w16");
        chk_tx("w16_id", 0, 8'h42);
        chk_tx("w16_addr_hi", 9, 8'h30);
        chk_tx("w16_addr_lo", 18, 8'h0A);
        chk_tx("w16_data", 27, 8'h82);
        check("w16_rises", rises, 37);
        check("w16_busy_len", busy_cnt, 304);
        check("w16_done_cnt", done_cnt, 1);

        // Port changes and extra start pulses after acceptance must be ignored
        do_start(1'b0, 1'b0, 16'h0011, 8'h3C);
        data = 8'hFF; addr = 16'h0077; rw = 1'b1;
        repeat (50) @(negedge clk);
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (100) @(negedge clk);
        start8 = 1'b1;
        repeat (3) @(negedge clk);
        start8 = 1'b0;
        wait_done("mid");
        chk_tx("mid_id", 0, 8'h42);
        chk_tx("mid_addr", 9, 8'h11);
        chk_tx("mid_data", 18, 8'h3C);
        check("mid_rises", rises, 28);
        check("mid_busy_len", busy_cnt, 232);
        check("mid_done_cnt", done_cnt, 1);
        check("mid_idle_after", {31'd0, busy8}, 32'd0);
        check("mid_rd_data_kept", {24'd0, rd8}, 32'hA5);

        // Reset during the address phase aborts to idle immediately
        do_start(1'b0, 1'b0, 16'h0021, 8'h5A);
        repeat (100) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_bus", {29'd0, c8, dout8, oe8}, 32'd7);
        check("abort_busy", {31'd0, busy8}, 32'd0);
        check("abort_rd_data", {24'd0, rd8}, 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        do_start(1'b0, 1'b0, 16'h006B, 8'h99);
        wait_done("post");
        chk_tx("post_id", 0, 8'h42);
        chk_tx("post_addr", 9, 8'h6B);
        chk_tx("post_data", 18, 8'h99);
        check("post_busy_len", busy_cnt, 232);
        check("post_done_cnt", done_cnt, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
